// File: rtl/mdr_pkg.sv
// mdr_pkg: shared FSM state and read-size encodings for the memory data register unit.
// Revision 1.0
`default_nettype none

package mdr_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } state_t;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

endpackage

`default_nettype wire

// File: rtl/mdr_extend.sv
// mdr_extend: widens a half-word or byte read to DATA_W bits, sign- or zero-extended.
// Revision 1.0
`default_nettype none

module mdr_extend
  import mdr_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic [1:0]        size_i,
  input  logic              sign_ext_i,
  output logic [DATA_W-1:0] data_o
);

  // Casting a signed slice up to DATA_W replicates its top bit.
  always_comb begin
    data_o = data_i;
    case (size_i)
      SZ_WORD: data_o = data_i;
      SZ_HALF: data_o = sign_ext_i ? DATA_W'($signed(data_i[15:0]))
                                   : DATA_W'(data_i[15:0]);
      SZ_BYTE: data_o = sign_ext_i ? DATA_W'($signed(data_i[7:0]))
                                   : DATA_W'(data_i[7:0]);
      default: data_o = data_i;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mdr_unit.sv
// mdr_unit: memory data register with bus load, memory read/write handshake and ack timeout.
// Revision 1.0
`default_nettype none

module mdr_unit
  import mdr_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              clear_n,
  input  logic [DATA_W-1:0] bus_mux_out,
  input  logic              mdr_in,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [DATA_W-1:0] mem_data_in,
  input  logic              mem_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_data_out,
  output logic [DATA_W-1:0] mdr_out,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int             CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   mdr_q, mdr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          size_q, size_d;
  logic                sext_q, sext_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   ext_data;

  mdr_extend #(.DATA_W(DATA_W)) u_extend (
    .data_i     (mem_data_in),
    .size_i     (size_q),
    .sign_ext_i (sext_q),
    .data_o     (ext_data)
  );

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= IDLE;
      mdr_q   <= '0;
      cnt_q   <= '0;
      size_q  <= SZ_WORD;
      sext_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mdr_q   <= mdr_d;
      cnt_q   <= cnt_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mdr_d   = mdr_q;
    cnt_d   = cnt_q;
    size_d  = size_q;
    sext_d  = sext_q;
    done_d  = 1'b0;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (mem_read) begin
          size_d  = size;
          sext_d  = sign_ext;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = RD_WAIT;
        end else if (mem_write) begin
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = WR_WAIT;
        end else if (mdr_in) begin
          mdr_d = bus_mux_out;
        end
      end
      RD_WAIT, WR_WAIT: begin
        // Ack is checked before the timeout so a last-cycle ack still completes.
        if (mem_ack) begin
          if (state_q == RD_WAIT) mdr_d = ext_data;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy         = (state_q != IDLE);
  assign mem_req      = (state_q != IDLE);
  assign mem_we       = (state_q == WR_WAIT);
  assign done         = done_q;
  assign err          = err_q;
  assign mdr_out      = mdr_q;
  assign mem_data_out = mdr_q;

endmodule

`default_nettype wire

// File: tb/tb_mdr_unit.sv
// tb_mdr_unit: randomized scoreboard bench for mdr_unit against an arithmetic reference model.
// Revision 1.0
`default_nettype none

module tb_mdr_unit;

  localparam int TO = 4;

  logic        clock = 1'b0;
  logic        clear_n = 1'b0;
  logic [31:0] bus_mux_out = '0;
  logic        mdr_in = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        sign_ext = 1'b0;
  logic [31:0] mem_data_in = '0;
  logic        mem_ack = 1'b0;
  logic        mem_req, mem_we, busy, done, err;
  logic [31:0] mem_data_out, mdr_out;

  mdr_unit #(.DATA_W(32), .TIMEOUT(TO)) dut (
    .clock        (clock),
    .clear_n      (clear_n),
    .bus_mux_out  (bus_mux_out),
    .mdr_in       (mdr_in),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .size         (size),
    .sign_ext     (sign_ext),
    .mem_data_in  (mem_data_in),
    .mem_ack      (mem_ack),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_data_out (mem_data_out),
    .mdr_out      (mdr_out),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          is_err;
    logic [31:0] mdr;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] m_mdr = '0;
  logic        err_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_ext(input logic [31:0] d, input logic [1:0] sz, input bit sx);
    int unsigned v;
    case (sz)
      2'b01: begin
        v = d % 65536;
        if (sx && v >= 32768) v = v + 32'hFFFF0000;
      end
      2'b10: begin
        v = d % 256;
        if (sx && v >= 128) v = v + 32'hFFFFFF00;
      end
      default: v = d;
    endcase
    return v;
  endfunction

  task automatic idle_inputs();
    mdr_in = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_ack = 1'b0;
  endtask

  // Monitor: every done pulse or err rise consumes one scoreboard entry.
  always @(negedge clock) begin
    if (clear_n && (done || (err && !err_prev))) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_event: got done=%0b err=%0b, expected no event", done, err);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("event_done_err", {30'd0, done, err}, e.is_err ? 32'd1 : 32'd2);
        chk("event_mdr", mdr_out, e.mdr);
      end
    end
    err_prev = err;
  end

  task automatic bus_load(input logic [31:0] v);
    @(negedge clock);
    idle_inputs();
    mdr_in = 1'b1;
    bus_mux_out = v;
    mem_ack = 1'($urandom);
    m_mdr = v;
    @(negedge clock);
    idle_inputs();
    chk("bus_load_mdr", mdr_out, v);
    chk("bus_load_busy", {31'd0, busy}, 32'd0);
    chk("bus_load_done", {31'd0, done}, 32'd0);
  endtask

  task automatic run_txn(input bit is_wr, input logic [1:0] sz, input bit sx,
                         input logic [31:0] data, input int dly, input bit crowd);
    bit          to;
    exp_t        e;
    logic [31:0] old_mdr;
    int          nreq;
    to = (dly >= TO);
    old_mdr = m_mdr;
    @(negedge clock);
    mem_read    = !is_wr;
    mem_write   = is_wr | crowd;
    mdr_in      = crowd;
    bus_mux_out = $urandom;
    size        = sz;
    sign_ext    = sx;
    mem_ack     = 1'($urandom);
    mem_data_in = $urandom;
    if (to) e.is_err = 1'b1;
    else begin
      e.is_err = 1'b0;
      if (!is_wr) m_mdr = ref_ext(data, sz, sx);
    end
    e.mdr = m_mdr;
    sb.push_back(e);
    nreq = 0;
    for (int k = 1; k <= TO; k++) begin
      @(negedge clock);
      if (k == 1) begin
        chk("start_err_clear", {31'd0, err}, 32'd0);
        chk("start_mem_we", {31'd0, mem_we}, {31'd0, is_wr});
        if (is_wr) chk("write_data", mem_data_out, old_mdr);
      end
      if (mem_req) nreq++;
      mem_read    = 1'($urandom);
      mem_write   = 1'($urandom);
      mdr_in      = 1'($urandom);
      bus_mux_out = $urandom;
      size        = 2'($urandom);
      sign_ext    = 1'($urandom);
      if (!to && k == dly + 1) begin
        mem_ack = 1'b1;
        mem_data_in = data;
        break;
      end
      mem_ack = 1'b0;
      mem_data_in = $urandom;
    end
    @(negedge clock);
    idle_inputs();
    chk("req_cycles", nreq, to ? TO : dly + 1);
    chk("end_busy", {31'd0, busy}, 32'd0);
    chk("end_err", {31'd0, err}, {31'd0, to});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done_err", {30'd0, done, err}, 32'd0);
    chk("rst_mdr_out", mdr_out, 32'd0);
    chk("rst_mem_data_out", mem_data_out, 32'd0);
    @(negedge clock);
    clear_n = 1'b1;

    bus_load(32'hDEADBEEF);
    run_txn(1'b0, 2'b10, 1'b1, 32'h12345680, 3, 1'b0);
    run_txn(1'b1, 2'b00, 1'b0, 32'h0, TO, 1'b0);
    run_txn(1'b0, 2'b00, 1'b0, 32'hCAFEF00D, 0, 1'b0);
    run_txn(1'b0, 2'b00, 1'b0, 32'h11223344, 1, 1'b1);
    run_txn(1'b0, 2'b01, 1'b0, 32'h0000ABCD, TO - 1, 1'b0);

    // Abort a read with a short reset pulse, then present a stale ack.
    @(negedge clock);
    mem_read = 1'b1; size = 2'b00;
    @(negedge clock);
    idle_inputs();
    @(negedge clock);
    #2 clear_n = 1'b0;
    #1;
    chk("abort_mem_req", {31'd0, mem_req}, 32'd0);
    chk("abort_mdr", mdr_out, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    m_mdr = '0;
    @(negedge clock);
    #2 clear_n = 1'b1;
    @(negedge clock);
    mem_ack = 1'b1; mem_data_in = 32'h55AA55AA;
    @(negedge clock);
    mem_ack = 1'b0;
    @(negedge clock);
    chk("post_abort_done", {31'd0, done}, 32'd0);
    chk("post_abort_mdr", mdr_out, 32'd0);

    for (int i = 0; i < 150; i++) begin
      int sel;
      sel = $urandom_range(0, 3);
      if (sel == 0) bus_load($urandom);
      else run_txn(sel == 1, 2'($urandom), 1'($urandom), $urandom,
                   $urandom_range(0, TO + 1), 1'($urandom));
    end

    repeat (3) @(negedge clock);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mdr_unit.md
MDR_UNIT -- requirements
Module: mdr_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, the MDR and data-path width in bits.
REQ-002 SHALL have parameter TIMEOUT, default 15, the maximum wait cycles for mem_ack before an error is flagged; legal range 1..255.
REQ-003 SHALL have port clock  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port clear_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port bus_mux_out  input  DATA_W  internal bus value, loaded by mdr_in.
REQ-006 SHALL have port mdr_in  input  1  load the MDR from bus_mux_out.
REQ-007 SHALL have port mem_read  input  1  start a memory read transaction.
REQ-008 SHALL have port mem_write  input  1  start a memory write of the current MDR.
REQ-009 SHALL have port size  input  2  read width: 00 = word, 01 = half (low 16 bits), 10 = byte (low 8 bits), 11 = word.
REQ-010 SHALL have port sign_ext  input  1  1 = sign-extend sub-word reads; 0 = zero-extend them.
REQ-011 SHALL have port mem_data_in  input  DATA_W  memory read data, valid when mem_ack = 1.
REQ-012 SHALL have port mem_ack  input  1  memory completion strobe.
REQ-013 SHALL have port mem_req  output  1  memory request, held high until ack or timeout.
REQ-014 SHALL have port mem_we  output  1  1 = write request, 0 = read request; qualified by mem_req.
REQ-015 SHALL have port mem_data_out  output  DATA_W  write data, equal to the MDR contents.
REQ-016 SHALL have port mdr_out  output  DATA_W  MDR contents, driven to the bus.
REQ-017 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-018 SHALL have port done  output  1  one-cycle pulse on successful completion of a transaction.
REQ-019 SHALL have port err  output  1  sticky timeout flag.

Function
REQ-020 SHALL implement the FSM states IDLE, RD_WAIT and WR_WAIT.
REQ-021 In IDLE, the start priority SHALL be mem_read > mem_write > mdr_in; the unit acts on only the highest-priority asserted request in a cycle.
REQ-022 IDLE with mdr_in (and no memory start) SHALL load the MDR from bus_mux_out on the next edge; the state stays IDLE and done is not pulsed.
REQ-023 IDLE with mem_read SHALL latch size and sign_ext, clear the wait counter, and move to RD_WAIT; mem_req = 1 and mem_we = 0 from the next cycle.
REQ-024 IDLE with mem_write SHALL clear the wait counter and move to WR_WAIT; mem_req = 1 and mem_we = 1 from the next cycle, and mem_data_out is held stable.
REQ-025 In RD_WAIT with mem_ack = 1, the unit SHALL:
- load the MDR with the width-adjusted mem_data_in (per the latched size and sign_ext);
- pulse done for one cycle;
- return to IDLE.
REQ-026 In WR_WAIT with mem_ack = 1, the unit SHALL pulse done, leave the MDR unchanged, and return to IDLE.
REQ-027 In either wait state, each cycle without ack SHALL increment the wait counter.
REQ-028 When the counter reaches TIMEOUT without ack, the unit SHALL:
- set err;
- leave the MDR unchanged;
- not pulse done;
- drop mem_req;
- return to IDLE.
REQ-029 If ack arrives in the same cycle the timeout would fire, ack SHALL win: normal completion, no err.
REQ-030 While busy, mdr_in, mem_read and mem_write SHALL be ignored, and the MDR SHALL not change except per REQ-025.
REQ-031 err SHALL clear only on reset or on the next accepted mem_read or mem_write start.
REQ-032 mem_ack in IDLE SHALL be ignored.
REQ-033 Minimum read latency SHALL be 2 cycles from mem_read to new data on mdr_out: request in cycle 1, ack in cycle 1, MDR updated at the following edge.
REQ-034 mdr_out and mem_data_out SHALL be registered MDR outputs with no combinational path from the inputs.
REQ-035 The wait counter width SHALL be the minimum needed to hold TIMEOUT; it SHALL not wrap before the compare.

Reset
REQ-036 While clear_n = 0, asynchronously:
- state = IDLE;
- MDR = 0;
- counter = 0;
- mem_req = mem_we = done = err = busy = 0;
- mdr_out = mem_data_out = 0.
REQ-037 Reset asserted mid-transaction SHALL abort it: mem_req drops immediately, and no done or err follows release.
REQ-038 The first request SHALL be accepted on the first rising edge after clear_n rises.

Structure
REQ-039 A shared package mdr_pkg SHALL hold the state enum (IDLE, RD_WAIT, WR_WAIT) and the size encodings (SZ_WORD, SZ_HALF, SZ_BYTE).
REQ-040 Sub-word extension SHALL be one combinational sub-module, mdr_extend (inputs: data, size, sign_ext; output: extended data), instantiated once.

Verification
REQ-041 Bus load: mdr_in = 1 with bus_mux_out = 0xDEADBEEF -> mdr_out = 0xDEADBEEF next cycle; busy = 0; no done.
REQ-042 Byte read, sign-extended: size = 10, sign_ext = 1, ack after 3 cycles with mem_data_in = 0x12345680 -> mdr_out = 0xFFFFFF80; done pulses once; busy high for 4 cycles.
REQ-043 Timeout with TIMEOUT = 4: mem_write, no ack -> mem_req high for 4 cycles, then err = 1, MDR unchanged, no done; a subsequent mem_read clears err.
REQ-044 Priority: mem_read, mem_write and mdr_in all high in IDLE -> RD_WAIT entered, mem_we = 0, MDR not loaded from the bus.
REQ-045 Reset during RD_WAIT: clear_n low for 1 cycle -> mem_req = 0 immediately and MDR = 0; an ack afterwards is ignored and done stays low.
REQ-046 Ack on the timeout cycle (TIMEOUT = 4, ack on the 4th wait cycle) with mem_data_in = 0x0000ABCD, size = 01, sign_ext = 0 -> mdr_out = 0x0000ABCD; done pulses; err = 0.
